pacman_sprite_renderer: RTL and testbench
=========================================

// Module: pacman_sprite_renderer
// PURPOSE
// Consumes the Pac-Man position (top-left, 10-bit x/y), the direction and a moving flag from the movement stage.
// Compares each scanned VGA pixel against a procedurally drawn Pac-Man disc with an animated, direction-rotated mouth.
// Emits a per-pixel hit and RGB value to the display mux, with fixed latency.
// Position and direction are sampled once per frame, so the sprite never tears mid-frame.
// PARAMETERS
// SIZE        16         sprite edge in pixels (even, 4..64)
// ANIM_FRAMES 4          frame_start pulses per mouth-phase step (>=1)
// COLOR       24'hFFFF00 RGB of a sprite pixel
// PORTS
// i_clk          in   1   pixel clock
// i_rst_n        in   1   reset: asynchronous, active-low
// i_pacman_x     in   10  sprite left column from movement stage
// i_pacman_y     in   10  sprite top row from movement stage
// i_dir          in   2   facing: 0 right, 1 left, 2 up, 3 down
// i_moving       in   1   1 = Pac-Man moved this frame; enables animation
// i_frame_start  in   1   one-cycle pulse at start of vertical blank
// i_pix_valid    in   1   active-video qualifier for i_pix_x/i_pix_y
// i_pix_x        in   10  current scan column
// i_pix_y        in   10  current scan row
// o_pix_valid    out  1   i_pix_valid delayed 2 cycles
// o_pix_hit      out  1   pixel belongs to sprite (qualified by o_pix_valid)
// o_pix_rgb      out  24  COLOR when hit, else 24'h000000
// BEHAVIOUR
// - Reset values:
//   - shadow x/y = 0, shadow dir = 0 (right), frame counter = 0, phase = CLOSED.
//   - Both pipeline stages cleared; all outputs 0.
// - Frame latch:
//   - On i_frame_start, shadow x/y/dir <= inputs; the new values take effect from the next cycle.
//   - A pixel arriving in the same cycle as i_frame_start uses the old shadow values.
// - Animation FSM (4 states): CLOSED -> HALF_OPEN -> OPEN -> HALF_CLOSE -> CLOSED.
//   - The counter increments on i_frame_start only when i_moving = 1.
//   - When the counter = ANIM_FRAMES-1 and increments, it wraps to 0 and the FSM advances one state.
//   - i_moving = 0 freezes both the counter and the state.
//   - i_moving is sampled together with i_frame_start.
// - Stage 1 (registered):
//   - dx = {1'b0,pix_x} - {1'b0,sx}, dy likewise, both 11-bit.
//   - inbox = !dx[10] && !dy[10] && dx < SIZE && dy < SIZE. Pixels left of or above the sprite wrap negative, so they miss.
//   - valid1 <= i_pix_valid.
// - Stage 2 (registered to outputs):
//   - Compute signed u = 2*dx-(SIZE-1) and v = 2*dy-(SIZE-1).
//   - disc = u*u + v*v <= SIZE*SIZE. Size the arithmetic so no overflow occurs for SIZE = 64.
//   - Axis a / perpendicular b by direction: right a=u, b=v; left a=-u, b=v; up a=-v, b=u; down a=v, b=u.
//   - mouth:
//     - CLOSED: never.
//     - HALF_*: a>0 && 2|b|<=a.
//     - OPEN: a>0 && |b|<=a.
//   - hit = valid1 && inbox && disc && !mouth.
//   - rgb = hit ? COLOR : 0.
// - Latency is exactly 2 cycles from i_pix_* to o_pix_*, fully pipelined with 1 pixel per cycle and no stalls.
// - Sprite partly beyond the screen edge: out-of-screen pixels are simply never scanned. No clipping logic is needed.
// - Mid-operation reset clears the pipeline and FSM immediately. The first valid output follows 2 cycles after release.
// TESTING
// 1. Reset, then frame_start with pos(100,50), dir 0. Pixel (107,57) valid -> 2 cycles later hit=1, rgb=FFFF00, valid=1.
// 2. Same pos. Pixel (100,50) -> hit=0 (corner outside disc). Pixel (99,57) -> hit=0 (out of box, dx negative).
// 3. moving=1, ANIM_FRAMES=4:
//    - after 4/8/12/16 frame_start -> phase HALF_OPEN/OPEN/HALF_CLOSE/CLOSED.
//    - moving=0 for 8 more pulses -> phase unchanged.
// 4. Phase OPEN, dir 0, pixel (115,57) -> hit=0 (mouth). Same pixel with dir 1 -> hit=1. Pixel (100,57) with dir 1 -> hit=0.
// 5. Mid-frame change of i_pacman_x to 200 -> pixels still hit at x=100..115 until the next frame_start, then at 200..215.
// 6. Assert i_rst_n low while o_pix_hit=1 -> all outputs 0 the same cycle. Back-to-back valid pixels give one output per cycle.

Source files
------------

// File: rtl/pacman_sprite_renderer.sv
// Pac-Man sprite renderer: per-frame latched position/direction, animated mouth,
// two-stage pixel pipeline producing hit and RGB with fixed 2-cycle latency.
module pacman_sprite_renderer #(
   parameter int          SIZE        = 16,
   parameter int          ANIM_FRAMES = 4,
   parameter logic [23:0] COLOR       = 24'hFFFF00
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [9:0]  i_pacman_x,
   input  logic [9:0]  i_pacman_y,
   input  logic [1:0]  i_dir,
   input  logic        i_moving,
   input  logic        i_frame_start,
   input  logic        i_pix_valid,
   input  logic [9:0]  i_pix_x,
   input  logic [9:0]  i_pix_y,
   output logic        o_pix_valid,
   output logic        o_pix_hit,
   output logic [23:0] o_pix_rgb
);

   localparam int LW = $clog2(SIZE);
   localparam int DW = LW + 3;
   localparam int PW = 2 * DW;
   localparam int CW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(ANIM_FRAMES - 1);
   localparam logic [10:0] SZ = 11'(SIZE);

   typedef enum logic [1:0] {CLOSED, HALF_OPEN, OPEN, HALF_CLOSE} phase_t;
   typedef logic signed [DW-1:0] sd_t;
   typedef logic signed [PW-1:0] sq_t;

   localparam sd_t OFS = sd_t'(SIZE - 1);
   localparam sq_t R2  = sq_t'(SIZE * SIZE);

   logic [9:0]    r_sx, r_sy;
   logic [1:0]    r_sdir;
   logic [CW-1:0] r_cnt;
   phase_t        r_phase;

   logic          r_valid1, r_inbox1;
   logic [LW-1:0] r_dx1, r_dy1;
   logic [1:0]    r_dir1;
   phase_t        r_phase1;

   logic [10:0]   w_dx, w_dy;
   logic          w_inbox;
   sd_t           w_u, w_v, w_a, w_b, w_babs;
   logic          w_disc, w_apos, w_half, w_open, w_mouth, w_hit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sx   <= '0;
         r_sy   <= '0;
         r_sdir <= '0;
      end else if (i_frame_start) begin
         r_sx   <= i_pacman_x;
         r_sy   <= i_pacman_y;
         r_sdir <= i_dir;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_phase <= CLOSED;
      end else if (i_frame_start && i_moving) begin
         if (r_cnt == CMAX) begin
            r_cnt <= '0;
            unique case (r_phase)
               CLOSED:     r_phase <= HALF_OPEN;
               HALF_OPEN:  r_phase <= OPEN;
               OPEN:       r_phase <= HALF_CLOSE;
               HALF_CLOSE: r_phase <= CLOSED;
            endcase
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Pixels left of / above the sprite wrap negative and set bit 10.
   assign w_dx    = {1'b0, i_pix_x} - {1'b0, r_sx};
   assign w_dy    = {1'b0, i_pix_y} - {1'b0, r_sy};
   assign w_inbox = !w_dx[10] && !w_dy[10] && (w_dx < SZ) && (w_dy < SZ);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid1 <= 1'b0;
         r_inbox1 <= 1'b0;
         r_dx1    <= '0;
         r_dy1    <= '0;
         r_dir1   <= '0;
         r_phase1 <= CLOSED;
      end else begin
         r_valid1 <= i_pix_valid;
         r_inbox1 <= w_inbox;
         r_dx1    <= w_dx[LW-1:0];
         r_dy1    <= w_dy[LW-1:0];
         r_dir1   <= r_sdir;
         r_phase1 <= r_phase;
      end
   end

   // Doubled coordinates centre the disc on the half-pixel grid.
   assign w_u = sd_t'({1'b0, r_dx1, 1'b0}) - OFS;
   assign w_v = sd_t'({1'b0, r_dy1, 1'b0}) - OFS;

   always_comb begin
      w_a = w_u;
      w_b = w_v;
      unique case (r_dir1)
         2'd0: begin w_a = w_u;  w_b = w_v; end
         2'd1: begin w_a = -w_u; w_b = w_v; end
         2'd2: begin w_a = -w_v; w_b = w_u; end
         2'd3: begin w_a = w_v;  w_b = w_u; end
      endcase
   end

   assign w_babs = w_b[DW-1] ? -w_b : w_b;
   assign w_disc = (sq_t'(w_u) * sq_t'(w_u) + sq_t'(w_v) * sq_t'(w_v)) <= R2;
   assign w_apos = !w_a[DW-1] && (w_a != '0);
   assign w_half = w_apos && ((w_babs <<< 1) <= w_a);
   assign w_open = w_apos && (w_babs <= w_a);

   always_comb begin
      w_mouth = 1'b0;
      unique case (r_phase1)
         CLOSED:     w_mouth = 1'b0;
         HALF_OPEN:  w_mouth = w_half;
         OPEN:       w_mouth = w_open;
         HALF_CLOSE: w_mouth = w_half;
      endcase
   end

   assign w_hit = r_valid1 && r_inbox1 && w_disc && !w_mouth;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pix_valid <= 1'b0;
         o_pix_hit   <= 1'b0;
         o_pix_rgb   <= '0;
      end else begin
         o_pix_valid <= r_valid1;
         o_pix_hit   <= w_hit;
         o_pix_rgb   <= w_hit ? COLOR : 24'h000000;
      end
   end

endmodule

// File: tb/tb_pacman_sprite_renderer.sv
// Self-checking bench for pacman_sprite_renderer against a geometric
// reference model with a 2-deep expected-output queue.
module tb_pacman_sprite_renderer;

   localparam int          SIZE  = 16;
   localparam int          AF    = 4;
   localparam logic [23:0] COLOR = 24'hFFFF00;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  pacx = '0, pacy = '0;
   logic [1:0]  dir = '0;
   logic        mov = 1'b0, fs = 1'b0, pv = 1'b0;
   logic [9:0]  px = '0, py = '0;
   logic        o_pix_valid, o_pix_hit;
   logic [23:0] o_pix_rgb;

   int n_chk = 0;
   int n_fail = 0;
   int msx = 0, msy = 0, mdir = 0, mcount = 0;
   logic [25:0] q[$];
   logic [25:0] e;

   pacman_sprite_renderer #(.SIZE(SIZE), .ANIM_FRAMES(AF), .COLOR(COLOR)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_pacman_x(pacx), .i_pacman_y(pacy), .i_dir(dir),
      .i_moving(mov), .i_frame_start(fs),
      .i_pix_valid(pv), .i_pix_x(px), .i_pix_y(py),
      .o_pix_valid(o_pix_valid), .o_pix_hit(o_pix_hit), .o_pix_rgb(o_pix_rgb)
   );

   always #5 clk = ~clk;

   function automatic logic [25:0] obs();
      return {o_pix_valid, o_pix_hit, o_pix_rgb};
   endfunction

   // Geometric model: box test, disc test, rotated mouth wedge.
   function automatic logic [25:0] model(bit vld, int x, int y, int sx,
                                         int sy, int d, int ph);
      int dx, dy, u, w, a, b, ab;
      bit m;
      if (!vld) return 26'd0;
      dx = x - sx;
      dy = y - sy;
      if (dx < 0 || dy < 0 || dx >= SIZE || dy >= SIZE) return {2'b10, 24'h0};
      u = 2 * dx - (SIZE - 1);
      w = 2 * dy - (SIZE - 1);
      if (u * u + w * w > SIZE * SIZE) return {2'b10, 24'h0};
      case (d)
         0: begin a = u;  b = w; end
         1: begin a = -u; b = w; end
         2: begin a = -w; b = u; end
         default: begin a = w; b = u; end
      endcase
      ab = (b < 0) ? -b : b;
      if (ph == 0) m = 0;
      else if (ph == 2) m = (a > 0) && (ab <= a);
      else m = (a > 0) && (2 * ab <= a);
      return m ? {2'b10, 24'h0} : {2'b11, COLOR};
   endfunction

   task automatic step(output logic [25:0] ex);
      q.push_back(model(pv, int'(px), int'(py), msx, msy, mdir, (mcount / AF) % 4));
      @(posedge clk);
      if (fs) begin
         msx = int'(pacx);
         msy = int'(pacy);
         mdir = int'(dir);
         if (mov) mcount++;
      end
      #1;
      ex = q.pop_front();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (o_pix_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b expected 0", o_pix_valid);
      end
      n_chk++;
      if (o_pix_hit !== 1'b0) begin
         n_fail++; $display("FAIL reset_hit: got %b expected 0", o_pix_hit);
      end
      n_chk++;
      if (o_pix_rgb !== 24'h0) begin
         n_fail++; $display("FAIL reset_rgb: got %h expected 0", o_pix_rgb);
      end
      rst_n = 1'b1;
      q.delete();
      q.push_back(26'd0);
   endtask

   task automatic test_frame_latch();
      int xs[5] = '{107, 100, 99, 115, 107};
      int ys[5] = '{57, 50, 57, 57, 66};
      pacx = 10'd100; pacy = 10'd50; dir = 2'd0; mov = 1'b0; fs = 1'b1; pv = 1'b0;
      step(e);
      fs = 1'b0;
      for (int i = 0; i < 7; i++) begin
         pv = (i < 5);
         if (i < 5) begin px = 10'(xs[i]); py = 10'(ys[i]); end
         step(e);
         n_chk++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL frame_latch[%0d]: got %h expected %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_anim();
      int pxs[3] = '{115, 113, 107};
      int pys[3] = '{57, 53, 57};
      for (int g = 0; g < 6; g++) begin
         mov = (g < 4);
         repeat ((g < 4) ? AF : 2 * AF) begin
            fs = 1'b1; pv = 1'b0;
            step(e);
            fs = 1'b0;
            n_chk++;
            if (obs() !== e) begin
               n_fail++; $display("FAIL anim_pulse: got %h expected %h", obs(), e);
            end
         end
         for (int i = 0; i < 8; i++) begin
            pv = (i < 6);
            if (i < 3) begin px = 10'(pxs[i]); py = 10'(pys[i]); end
            else begin
               px = 10'(100 + $urandom_range(0, SIZE - 1));
               py = 10'(50 + $urandom_range(0, SIZE - 1));
            end
            step(e);
            n_chk++;
            if (obs() !== e) begin
               n_fail++; $display("FAIL anim[g%0d,%0d]: got %h expected %h", g, i, obs(), e);
            end
         end
      end
   endtask

   task automatic test_dir_open();
      int pxs[4] = '{115, 100, 107, 107};
      int pys[4] = '{57, 57, 50, 65};
      mov = 1'b1;
      repeat (2 * AF) begin
         fs = 1'b1; pv = 1'b0;
         step(e);
      end
      mov = 1'b0;
      for (int d = 0; d < 4; d++) begin
         dir = 2'(d); fs = 1'b1; pv = 1'b0;
         step(e);
         fs = 1'b0;
         for (int i = 0; i < 16; i++) begin
            pv = (i < 14);
            if (i < 4) begin px = 10'(pxs[i]); py = 10'(pys[i]); end
            else begin
               px = 10'(100 + $urandom_range(0, SIZE - 1));
               py = 10'(50 + $urandom_range(0, SIZE - 1));
            end
            step(e);
            n_chk++;
            if (obs() !== e) begin
               n_fail++; $display("FAIL dir_open[d%0d,%0d]: got %h expected %h", d, i, obs(), e);
            end
         end
      end
      dir = 2'd0; fs = 1'b1; pv = 1'b0;
      step(e);
      fs = 1'b0;
   endtask

   task automatic test_mid_frame();
      pacx = 10'd200;
      for (int pass = 0; pass < 2; pass++) begin
         for (int x = 95; x <= 222; x++) begin
            pv = (x <= 220); px = 10'(x); py = 10'd57;
            step(e);
            n_chk++;
            if (obs() !== e) begin
               n_fail++; $display("FAIL mid_frame[p%0d,x%0d]: got %h expected %h", pass, x, obs(), e);
            end
         end
         fs = 1'b1; pv = 1'b0;
         step(e);
         fs = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 3) begin
            pacx = 10'($urandom_range(0, 1000));
            pacy = 10'($urandom_range(0, 1000));
         end
         dir = 2'($urandom_range(0, 3));
         mov = 1'($urandom_range(0, 3) != 0);
         fs = ($urandom_range(0, 29) == 0);
         pv = ($urandom_range(0, 7) != 0);
         px = 10'((msx + int'($urandom_range(0, SIZE + 3)) - 2) & 1023);
         py = 10'((msy + int'($urandom_range(0, SIZE + 3)) - 2) & 1023);
         step(e);
         n_chk++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL back_to_back[%0d]: got %h expected %h", c, obs(), e);
         end
      end
      fs = 1'b0; pv = 1'b0;
   endtask

   task automatic test_mid_reset();
      bit seen = 0;
      pacx = 10'd300; pacy = 10'd200; dir = 2'd0; mov = 1'b0; fs = 1'b1; pv = 1'b0;
      step(e);
      fs = 1'b0; pv = 1'b1; px = 10'd307; py = 10'd207;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(e);
         n_chk++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL mid_reset_pre[%0d]: got %h expected %h", i, obs(), e);
         end
         if (o_pix_hit === 1'b1) seen = 1;
      end
      n_chk++;
      if (!seen) begin
         n_fail++; $display("FAIL mid_reset_hit_wait: got hit=0 within 10 cycles, expected 1");
      end
      #3;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (obs() !== 26'd0) begin
         n_fail++; $display("FAIL mid_reset_async: got %h expected 0", obs());
      end
      msx = 0; msy = 0; mdir = 0; mcount = 0;
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.push_back(26'd0);
      for (int i = 0; i < 8; i++) begin
         fs = (i == 2);
         step(e);
         n_chk++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL mid_reset_post[%0d]: got %h expected %h", i, obs(), e);
         end
      end
      fs = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame_latch();
      test_anim();
      test_dir_open();
      test_mid_frame();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
